i2c_reg_master: RTL and testbench
=================================

I2C_REG_MASTER -- requirements
Module: i2c_reg_master

Interface
REQ-001 Parameter CLK_DIV, default 125, clk cycles per SCL quarter-phase tick (50 MHz / (4*125) = 100 kHz SCL).
REQ-002 clk  input  1  system clock, 50 MHz.
REQ-003 rst_l  input  1  reset, asynchronous, active-low.
REQ-004 req  input  1  transaction request; sampled only while busy=0.
REQ-005 rnw  input  1  1 = register read, 0 = register write.
REQ-006 dev_addr  input  7  target 7-bit I2C address (PCA9555-class expander).
REQ-007 reg_addr  input  8  target command/register byte.
REQ-008 wr_data  input  8  write data byte.
REQ-009 busy  output  1  transaction in progress.
REQ-010 done  output  1  one-cycle pulse at transaction end.
REQ-011 ack_err  output  1  last transaction saw a NACK; valid with done, held until next accept.
REQ-012 rd_data  output  8  last byte read; updated only by a successful read.
REQ-013 scl_i, sda_i  input  1 each  bus line levels.
REQ-014 scl_oe, sda_oe  output  1 each  1 = pull line low, 0 = release (open-drain).

Function
REQ-015 scl_i/sda_i SHALL pass through a 2-flop synchronizer before use.
REQ-016 Tick counter SHALL count 0..CLK_DIV-1 while busy and emit one tick per wrap; the counter SHALL be held at 0 while idle.
REQ-017 Each bit SHALL span 4 ticks: phase 0 SCL low, SDA updated; phases 1-2 SCL released; phase 3 SCL low; sampling of SDA at the end of phase 2.
REQ-018 Clock stretching: in phases 1-2, if scl_oe=0 and synchronized scl_i=0, the tick counter SHALL hold.
REQ-019 Accept: when req=1 and busy=0, the block SHALL latch rnw, dev_addr, reg_addr, wr_data, clear ack_err, and set busy=1 on the next cycle.
REQ-020 req while busy=1 SHALL be ignored, with no queuing.
REQ-021 States: IDLE, START, ADDR_W, ACK1, REG, ACK2, WDATA, ACK3, RSTART, ADDR_R, ACK4, RDATA, MNACK, STOP.
REQ-022 START (4 ticks): SDA released with SCL high, then SDA low while SCL high, then SCL low.
REQ-023 Write sequence SHALL be START, ADDR_W ({dev_addr,0}, MSB first), ACK1, REG, ACK2, WDATA, ACK3, STOP; total 116 ticks.
REQ-024 Read sequence SHALL be START, ADDR_W, ACK1, REG, ACK2, RSTART (4 ticks, repeated start), ADDR_R ({dev_addr,1}), ACK4, RDATA (8 bits shifted in MSB first, sda_oe=0), MNACK (master drives SDA high), STOP; total 156 ticks.
REQ-025 ACK states SHALL release SDA and sample it; sampled 1 = NACK -> set ack_err=1 and go directly to STOP.
REQ-026 STOP (4 ticks): SDA low, SCL released, then SDA released while SCL high.
REQ-027 At STOP completion, done=1 for exactly one cycle, busy=0 in the same cycle, and the state SHALL return to IDLE.
REQ-028 rd_data SHALL load at MNACK entry only on a read with ack_err=0.
REQ-029 In IDLE, scl_oe=0 and sda_oe=0.

Reset
REQ-030 rst_l=0 SHALL force the following immediately: state IDLE, scl_oe=0, sda_oe=0, busy=0, done=0, ack_err=0, rd_data=8'h00, tick counter 0, synchronizers 1.
REQ-031 Reset mid-transaction SHALL release both lines with no STOP generated; the first req after reset SHALL start a fresh transaction.

Verification (CLK_DIV=4, slave model ACKs unless noted)
REQ-032 Write dev 7'h20, reg 8'h02, data 8'hA5 -> bus bytes 8'h40, 8'h02, 8'hA5; done at 116*4 cycles after accept (+/- 2); ack_err=0.
REQ-033 Read dev 7'h20, reg 8'h00, slave returns 8'h3C -> bytes 8'h40, 8'h00, repeated start, 8'h41; rd_data=8'h3C; MNACK seen; done at 156*4 cycles.
REQ-034 Address NACK on write -> STOP immediately after ACK1; ack_err=1 with done; rd_data unchanged.
REQ-035 Slave holds SCL low 20 cycles during ACK2 -> transaction stretches 20 cycles; data intact.
REQ-036 rst_l low during RDATA bit 3 -> scl_oe=sda_oe=0 and busy=0 in the same cycle; a new write afterward completes normally.
REQ-037 req pulsed while busy -> ignored; exactly one done; no second transaction.

Source files
------------

// File: rtl/i2c_reg_master.sv
// rtl/i2c_reg_master.sv - I2C register read/write master for PCA9555-class expanders
module i2c_reg_master #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       req,
    input  logic       rnw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rd_data,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, START, ADDR_W, ACK1, REG, ACK2, WDATA, ACK3,
        RSTART, ADDR_R, ACK4, RDATA, MNACK, STOP
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    phase;
    logic [2:0]    bit_idx;
    logic [CW-1:0] cnt;
    logic [1:0]    scl_sync, sda_sync, scl_oe_d;
    logic          rnw_q;
    logic [6:0]    dev_q;
    logic [7:0]    reg_q, wr_q, rx_shift, tx_byte;
    logic          scl_s, sda_s, stretch, tick, is_ack;

    assign scl_s  = scl_sync[1];
    assign sda_s  = sda_sync[1];
    assign busy   = (state != IDLE);
    assign is_ack = state inside {ACK1, ACK2, ACK3, ACK4};

    // Only treat SCL as held low once our own release has had time to cross the synchronizer.
    assign stretch = (phase == 2'd1 || phase == 2'd2) && !scl_oe && !scl_oe_d[1] && !scl_s;
    assign tick    = busy && !stretch && (cnt == CNT_MAX);

    always_comb begin
        tx_byte = 8'h00;
        case (state)
            ADDR_W:  tx_byte = {dev_q, 1'b0};
            REG:     tx_byte = reg_q;
            WDATA:   tx_byte = wr_q;
            ADDR_R:  tx_byte = {dev_q, 1'b1};
            default: tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state)
            IDLE: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
            START: begin
                scl_oe = (phase == 2'd3);
                sda_oe = (phase >= 2'd2);
            end
            RSTART: begin
                scl_oe = (phase == 2'd0) || (phase == 2'd3);
                sda_oe = (phase >= 2'd2);
            end
            STOP: begin
                scl_oe = (phase == 2'd0);
                sda_oe = (phase <= 2'd1);
            end
            ADDR_W, REG, WDATA, ADDR_R: begin
                scl_oe = (phase == 2'd0) || (phase == 2'd3);
                sda_oe = ~tx_byte[bit_idx];
            end
            default: begin
                scl_oe = (phase == 2'd0) || (phase == 2'd3);
                sda_oe = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req) state_nxt = START;
            default: begin
                if (tick && phase == 2'd3) begin
                    case (state)
                        START:   state_nxt = ADDR_W;
                        ADDR_W:  if (bit_idx == 3'd0) state_nxt = ACK1;
                        ACK1:    state_nxt = ack_err ? STOP : REG;
                        REG:     if (bit_idx == 3'd0) state_nxt = ACK2;
                        ACK2:    state_nxt = ack_err ? STOP : (rnw_q ? RSTART : WDATA);
                        WDATA:   if (bit_idx == 3'd0) state_nxt = ACK3;
                        ACK3:    state_nxt = STOP;
                        RSTART:  state_nxt = ADDR_R;
                        ADDR_R:  if (bit_idx == 3'd0) state_nxt = ACK4;
                        ACK4:    state_nxt = ack_err ? STOP : RDATA;
                        RDATA:   if (bit_idx == 3'd0) state_nxt = MNACK;
                        MNACK:   state_nxt = STOP;
                        STOP:    state_nxt = IDLE;
                        default: state_nxt = IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            phase    <= 2'd0;
            bit_idx  <= 3'd7;
            cnt      <= '0;
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_oe_d <= 2'b00;
            rnw_q    <= 1'b0;
            dev_q    <= 7'h00;
            reg_q    <= 8'h00;
            wr_q     <= 8'h00;
            rx_shift <= 8'h00;
            ack_err  <= 1'b0;
            rd_data  <= 8'h00;
            done     <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_oe_d <= {scl_oe_d[0], scl_oe};
            done     <= 1'b0;
            if (state == IDLE) begin
                cnt     <= '0;
                phase   <= 2'd0;
                bit_idx <= 3'd7;
                if (req) begin
                    rnw_q   <= rnw;
                    dev_q   <= dev_addr;
                    reg_q   <= reg_addr;
                    wr_q    <= wr_data;
                    ack_err <= 1'b0;
                end
            end else begin
                if (!stretch) cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
                if (tick) begin
                    phase <= phase + 2'd1;
                    if (phase == 2'd2) begin
                        if (is_ack && sda_s) ack_err <= 1'b1;
                        if (state == RDATA) rx_shift <= {rx_shift[6:0], sda_s};
                    end
                    if (phase == 2'd3) begin
                        bit_idx <= (state_nxt != state) ? 3'd7 : bit_idx - 3'd1;
                        if (state == RDATA && state_nxt == MNACK && rnw_q && !ack_err)
                            rd_data <= rx_shift;
                        if (state == STOP) done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_master.sv
// tb/tb_i2c_reg_master.sv - self-checking bench with bus monitor and register-slave model
module tb_i2c_reg_master;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       req = 1'b0;
    logic       rnw = 1'b0;
    logic [6:0] dev_addr = 7'h00;
    logic [7:0] reg_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       busy, done, ack_err;
    logic [7:0] rd_data;
    logic       scl_oe, sda_oe;
    logic       scl_line, sda_line;

    logic       slv_sda_low = 1'b0;
    int         hold_cnt = 0;

    assign scl_line = ~(scl_oe | (hold_cnt != 0));
    assign sda_line = ~(sda_oe | slv_sda_low);

    always #10 clk = ~clk;

    i2c_reg_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst_l    (rst_l),
        .req      (req),
        .rnw      (rnw),
        .dev_addr (dev_addr),
        .reg_addr (reg_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .rd_data  (rd_data),
        .scl_i    (scl_line),
        .sda_i    (sda_line),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe)
    );

    logic [6:0] slv_addr = 7'h20;
    logic [7:0] slv_rdval = 8'h00;
    int         stretch_n = 0;
    int         stretch_byte = 0;
    logic       mon_clear = 1'b0;

    logic       prev_scl, prev_sda, in_frame, first_byte, rd_mode, addr_ok;
    logic [7:0] shreg;
    int         bitcnt, byte_cnt, frame_bytes, mon_starts, mon_stops, done_cnt;
    logic [7:0] mon_bytes[$];
    logic       mon_acks[$];

    // Bus monitor plus an addressable register slave that ACKs writes and returns slv_rdval.
    always @(posedge clk) begin
        if (!rst_l || mon_clear) begin
            slv_sda_low <= 1'b0;
            hold_cnt    <= 0;
            in_frame    = 1'b0;
            first_byte  = 1'b0;
            rd_mode     = 1'b0;
            addr_ok     = 1'b0;
            shreg       = 8'h00;
            bitcnt      = 0;
            byte_cnt    = 0;
            frame_bytes = 0;
            mon_starts  = 0;
            mon_stops   = 0;
            done_cnt    = 0;
            mon_bytes.delete();
            mon_acks.delete();
            prev_scl    = scl_line;
            prev_sda    = sda_line;
        end else begin
            if (done) done_cnt++;
            if (hold_cnt != 0 && !scl_oe) hold_cnt <= hold_cnt - 1;
            if (prev_scl && scl_line && prev_sda && !sda_line) begin
                mon_starts++;
                in_frame    = 1'b1;
                first_byte  = 1'b1;
                bitcnt      = 0;
                frame_bytes = 0;
                shreg       = 8'h00;
            end else if (prev_scl && scl_line && !prev_sda && sda_line) begin
                mon_stops++;
                in_frame = 1'b0;
                bitcnt   = 0;
            end else if (in_frame && !prev_scl && scl_line) begin
                if (bitcnt < 8) shreg = {shreg[6:0], sda_line};
                else if (bitcnt == 8) mon_acks.push_back(sda_line);
                bitcnt++;
            end else if (in_frame && prev_scl && !scl_line) begin
                if (bitcnt == 8) begin
                    mon_bytes.push_back(shreg);
                    if (stretch_n > 0 && byte_cnt == stretch_byte) hold_cnt <= stretch_n;
                    byte_cnt++;
                    frame_bytes++;
                    if (first_byte) begin
                        first_byte = 1'b0;
                        rd_mode    = shreg[0];
                        addr_ok    = (shreg[7:1] == slv_addr);
                        slv_sda_low <= addr_ok;
                    end else begin
                        slv_sda_low <= !rd_mode;
                    end
                end else if (bitcnt == 9) begin
                    bitcnt = 0;
                    if (rd_mode && addr_ok && frame_bytes == 1) slv_sda_low <= ~slv_rdval[7];
                    else slv_sda_low <= 1'b0;
                end else if (bitcnt >= 1 && bitcnt <= 7 && rd_mode && addr_ok && frame_bytes == 1) begin
                    slv_sda_low <= ~slv_rdval[7 - bitcnt];
                end
            end
            prev_scl = scl_line;
            prev_sda = sda_line;
        end
    end

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_bytes[$];
    logic       exp_acks[$];
    int         exp_ticks, exp_starts;
    logic       exp_err;
    logic [7:0] exp_rd = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp, input int tol);
        n_checks++;
        assert (obs >= exp - tol && obs <= exp + tol) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, exp, tol);
        end
    endtask

    // Transaction-level expectation: one 36-tick frame per byte, plus start/restart/stop.
    task automatic model_txn(input logic r, input logic [6:0] d, input logic [7:0] rg,
                             input logic [7:0] wr, input logic [7:0] rv, input logic nack);
        exp_bytes.delete();
        exp_acks.delete();
        exp_bytes.push_back({d, 1'b0});
        exp_acks.push_back(nack);
        if (!nack) begin
            exp_bytes.push_back(rg);
            exp_acks.push_back(1'b0);
            if (r) begin
                exp_bytes.push_back({d, 1'b1});
                exp_acks.push_back(1'b0);
                exp_bytes.push_back(rv);
                exp_acks.push_back(1'b1);
                exp_rd = rv;
            end else begin
                exp_bytes.push_back(wr);
                exp_acks.push_back(1'b0);
            end
        end
        exp_starts = (r && !nack) ? 2 : 1;
        exp_ticks  = 4 + 36 * exp_bytes.size() + ((exp_starts == 2) ? 4 : 0) + 4;
        exp_err    = nack;
    endtask

    task automatic clear_mon();
        @(negedge clk) mon_clear = 1'b1;
        @(negedge clk) mon_clear = 1'b0;
    endtask

    task automatic run_txn(input string name, input logic r, input logic [6:0] d,
                           input logic [7:0] rg, input logic [7:0] wr, input logic [6:0] sa,
                           input logic [7:0] rv, input int sbyte, input int sn, input logic poke);
        int  lat;
        int  exp_lat;
        logic got;
        slv_addr     = sa;
        slv_rdval    = rv;
        stretch_byte = sbyte;
        stretch_n    = sn;
        clear_mon();
        model_txn(r, d, rg, wr, rv, sa != d);
        exp_lat = exp_ticks * CLK_DIV + ((sn > 0 && sbyte < exp_bytes.size()) ? sn : 0);
        @(negedge clk);
        rnw = r; dev_addr = d; reg_addr = rg; wr_data = wr; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 3000) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) got = 1'b1;
            if (poke && lat == 40) begin req = 1'b1; rnw = ~r; end
            else if (poke && lat == 41) req = 1'b0;
        end
        check({name, "_done_seen"}, got, 1'b1);
        check_near({name, "_latency"}, lat, exp_lat, 2);
        check({name, "_busy_at_done"}, busy, 1'b0);
        check({name, "_ack_err"}, ack_err, exp_err);
        check({name, "_rd_data"}, rd_data, exp_rd);
        @(posedge clk);
        #1 check({name, "_done_pulse"}, done, 1'b0);
        repeat (poke ? 700 : 5) @(posedge clk);
        #1;
        check({name, "_done_count"}, done_cnt, 1);
        check({name, "_idle_busy"}, busy, 1'b0);
        check({name, "_starts"}, mon_starts, exp_starts);
        check({name, "_stops"}, mon_stops, 1);
        check({name, "_nbytes"}, mon_bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < mon_bytes.size(); i++)
            check($sformatf("%s_byte%0d", name, i), mon_bytes[i], exp_bytes[i]);
        check({name, "_nacks"}, mon_acks.size(), exp_acks.size());
        for (int i = 0; i < exp_acks.size() && i < mon_acks.size(); i++)
            check($sformatf("%s_ackbit%0d", name, i), mon_acks[i], exp_acks[i]);
    endtask

    initial begin
        logic       reached;
        logic       rr;
        logic [6:0] dd, sa;
        logic [7:0] rg, wd, rv;

        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ack_err", ack_err, 1'b0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_scl_oe", scl_oe, 1'b0);
        check("rst_sda_oe", sda_oe, 1'b0);
        @(negedge clk) rst_l = 1'b1;
        repeat (2) @(negedge clk);

        run_txn("wr_a5", 1'b0, 7'h20, 8'h02, 8'hA5, 7'h20, 8'h00, 0, 0, 1'b0);
        run_txn("rd_3c", 1'b1, 7'h20, 8'h00, 8'h00, 7'h20, 8'h3C, 0, 0, 1'b0);
        run_txn("addr_nack", 1'b0, 7'h20, 8'h06, 8'h55, 7'h21, 8'h00, 0, 0, 1'b0);
        run_txn("stretch", 1'b0, 7'h24, 8'h03, 8'h5A, 7'h24, 8'h00, 1, 20, 1'b0);
        run_txn("req_busy", 1'b0, 7'h27, 8'h07, 8'hC3, 7'h27, 8'h00, 0, 0, 1'b1);

        for (int k = 0; k < 10; k++) begin
            rr = 1'($urandom_range(0, 1));
            dd = 7'($urandom);
            rg = 8'($urandom);
            wd = 8'($urandom);
            rv = 8'($urandom);
            sa = ($urandom_range(0, 3) == 0) ? (dd ^ 7'h05) : dd;
            run_txn($sformatf("rnd%0d", k), rr, dd, rg, wd, sa, rv, 0, 0, 1'b0);
        end

        slv_addr  = 7'h33;
        slv_rdval = 8'h96;
        stretch_n = 0;
        clear_mon();
        @(negedge clk);
        rnw = 1'b1; dev_addr = 7'h33; reg_addr = 8'h10; req = 1'b1;
        @(negedge clk) req = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 3000 && !reached; c++) begin
            @(negedge clk);
            if (mon_bytes.size() == 3 && bitcnt == 4) reached = 1'b1;
        end
        check("reach_rdata_bit3", reached, 1'b1);
        rst_l = 1'b0;
        #1;
        check("midrst_scl_oe", scl_oe, 1'b0);
        check("midrst_sda_oe", sda_oe, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        exp_rd = 8'h00;
        #1 check("midrst_rd_data", rd_data, 8'h00);
        repeat (2) @(negedge clk);
        run_txn("post_rst_wr", 1'b0, 7'h11, 8'h04, 8'h3E, 7'h11, 8'h00, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
